// File: rtl/sec32_check_encoder.sv
// Transmit-side SEC encoder: 32 data bits -> 40-bit codeword, 1-cycle latency, two-entry (output + skid) buffer.
// Optional one-shot bit-flip injection is compiled in with `define SEC_ERR_INJECT_EN.
module sec32_check_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [31:0]      s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [31:0]      m_data,
  output logic [7:0]       m_check,
  input  logic             inj_req,
  input  logic [5:0]       inj_pos,
  output logic [CNT_W-1:0] word_cnt
);

  localparam logic [31:0] MASK [8] = '{
    32'h00FF1111, 32'hFF002222, 32'h0F0F4444, 32'hF0F08888,
    32'h111100FF, 32'h2222FF00, 32'h44440F0F, 32'h8888F0F0
  };

  function automatic logic [7:0] sec_check(input logic [31:0] d);
    logic [7:0] c;
    c = '0;
    for (int k = 0; k < 8; k++) c[k] = ^(d & MASK[k]);
    return c;
  endfunction

  typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_t;

  occ_t        state, state_nxt;
  logic        s_ready_q;
  logic [39:0] out_cw, skid_cw, in_cw, load_cw, flip;
  logic        accept, drain;
  logic        load_out, load_from_skid, load_skid;

  assign accept  = s_valid & s_ready_q;
  assign drain   = m_valid & m_ready;
  assign in_cw   = {sec_check(s_data), s_data};
  assign s_ready = s_ready_q;
  assign m_valid = (state != EMPTY);
  assign m_data  = out_cw[31:0];
  assign m_check = out_cw[39:32];

  always_comb begin
    state_nxt      = state;
    load_out       = 1'b0;
    load_from_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: if (accept) begin
        state_nxt = ONE;
        load_out  = 1'b1;
      end
      ONE: begin
        if (accept && drain) begin
          load_out = 1'b1;
        end else if (accept) begin
          state_nxt = FULL;
          load_skid = 1'b1;
        end else if (drain) begin
          state_nxt = EMPTY;
        end
      end
      FULL: if (drain) begin
        state_nxt      = ONE;
        load_out       = 1'b1;
        load_from_skid = 1'b1;
      end
      default: state_nxt = EMPTY;
    endcase
  end

`ifdef SEC_ERR_INJECT_EN
  logic       inj_armed;
  logic [5:0] inj_pos_q;
  logic       armed_now;
  logic [5:0] pos_now;

  // A request on the load cycle itself takes effect on that word.
  assign armed_now = inj_armed | inj_req;
  assign pos_now   = inj_req ? inj_pos : inj_pos_q;
  assign flip      = (armed_now && pos_now < 6'd40) ? (40'd1 << pos_now) : 40'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inj_armed <= 1'b0;
      inj_pos_q <= '0;
    end else begin
      if (inj_req) inj_pos_q <= inj_pos;
      if (load_out)     inj_armed <= 1'b0;
      else if (inj_req) inj_armed <= 1'b1;
    end
  end
`else
  logic unused_inj;
  assign unused_inj = ^{inj_req, inj_pos};
  assign flip       = 40'd0;
`endif

  assign load_cw = (load_from_skid ? skid_cw : in_cw) ^ flip;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      s_ready_q <= 1'b0;
      out_cw    <= '0;
      skid_cw   <= '0;
      word_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      s_ready_q <= (state_nxt != FULL);
      if (load_out)  out_cw  <= load_cw;
      if (load_skid) skid_cw <= in_cw;
      if (drain)     word_cnt <= word_cnt + CNT_W'(1);
    end
  end

endmodule
